mult16_share_arbiter: RTL
=========================

Name: mult16_share_arbiter

Overview:
- Shares one 16x16 unsigned hard multiplier among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester; one transaction in flight at a time.
- Operands and product are registered around the mult_16 macro (MODE=0), which is instantiated inside this block. The returned product is tagged with the requester ID.
- Sits between DSP-sharing benchmark logic and the single mult_16 resource.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_WIDTH, 2: width of rsp_id; must satisfy 2**ID_WIDTH >= NUM_REQ.
- DATA_WIDTH, 16: operand width. Fixed at 16 to match mult_16; any other value is a configuration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*16  operand A, flattened; requester i uses bits [16i+15:16i].
- req_b  in  NUM_REQ*16  operand B, same packing as req_a.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts product.
- rsp_id  out  ID_WIDTH  index of the requester owning the product.
- rsp_data  out  32  unsigned product a*b.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- All state changes occur on the rising edge of clk. rst is sampled synchronously.
- Reset values:
  - FSM = IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - Operand registers = 0.
  - RR pointer last = NUM_REQ-1, so requester 0 has first priority after reset.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Select winner w = the first i with req_valid[i] set, searching from (last+1) mod NUM_REQ upward with wrap.
  - req_ready[w] = 1 combinationally in the same cycle; all other ready bits are 0.
  - On a handshake, capture req_a/req_b of w into the operand registers and the ID register, set last = w, go to MUL.
  - If no req_valid bit is set, stay in IDLE and hold last.
- MUL: the mult_16 output (fed from the operand registers) is registered into rsp_data; go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id and rsp_data stay stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE.
  - While rsp_ready = 0, hold everything; req_ready stays all-zero.
- Latency:
  - Request handshake at cycle T gives rsp_valid at T+2.
  - With rsp_ready held at 1, the next grant occurs at T+3, so maximum throughput is 1 op per 3 cycles.
- Arithmetic:
  - Unsigned full-width product; no truncation.
  - 0xFFFF*0xFFFF = 0xFFFE0001.
- Requester rules:
  - A requester must hold req_valid and its operands stable until req_ready.
  - Deasserting req_valid before it is granted is permitted; it simply loses its turn.
  - The arbiter never grants a requester whose req_valid is 0.
- Simultaneous events:
  - Several requesters valid: exactly one is granted, chosen by the RR order above.
  - Any requester that stays valid is granted within NUM_REQ grants (no starvation).
- Reset mid-operation (rst in MUL or RESP): the in-flight product is discarded, rsp_valid drops on the next edge, the pointer returns to NUM_REQ-1, and no response is ever issued for that transaction.
- Unused IDs: for i >= NUM_REQ, req lanes do not exist and rsp_id never takes those values.

Test Plan:
1. Reset, then only req 2 valid with a=3, b=5 -> req_ready[2]=1 in that cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_data=15.
2. All 4 requesters held valid with a=i+1, b=0x100, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_data sequence 0x100, 0x200, 0x300, 0x400; one grant every 3 cycles.
3. a=0xFFFF, b=0xFFFF on req 1 -> rsp_data=0xFFFE0001; a=0, b=0xABCD -> rsp_data=0.
4. Backpressure: rsp_ready=0 for 5 cycles while RESP -> rsp_valid, rsp_id and rsp_data stay constant, all req_ready bits stay 0, busy=1; raising rsp_ready completes the response and the next grant follows one cycle later.
5. Assert rst for 1 cycle while in MUL with req 3 in flight -> no response for req 3; after reset, with reqs 0 and 3 both valid, req 0 is granted first.
6. Fairness: req 0 continuously valid, req 1 pulsed valid -> req 1 is granted at the next grant after req 0's current grant, never skipped twice.

Source files
------------

// File: rtl/mult16_share_arbiter.sv
// mult16_share_arbiter
// Shares one 16x16 unsigned hard multiplier (mult_16, MODE=0) among NUM_REQ
// requesters. Round-robin arbitration, one transaction in flight at a time.
// Operands are registered in front of the multiplier and the product is
// registered behind it. Each returned product is tagged with the requester ID.
// The request-side ready is combinational: the grant is visible in the same
// cycle as the valid that earns it.

// Behavioural model of the mult_16 hard macro. MODE=0 is the unsigned
// full-width product, which is the only mode this arbiter uses.
module mult_16 #(
    parameter int MODE = 0
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] out
);

    // Multiplier array: unsigned product for MODE 0, signed product otherwise.
    always_comb begin
        out = 32'd0;
        if (MODE == 0) begin
            out = {16'd0, a} * {16'd0, b};
        end else begin
            out = 32'($signed(a) * $signed(b));
        end
    end

endmodule

module mult16_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    output logic                            busy
);

    // DATA_WIDTH must stay 16: the operand and product registers are wired
    // straight onto the fixed-width mult_16 ports.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int ID_SPAN = 1 << ID_WIDTH;

    state_t                     state_r;
    state_t                     state_nxt_s;

    logic [ID_WIDTH-1:0]        last_r;
    logic [ID_WIDTH-1:0]        id_r;
    logic [DATA_WIDTH-1:0]      op_a_r;
    logic [DATA_WIDTH-1:0]      op_b_r;

    logic                       rsp_valid_r;
    logic [ID_WIDTH-1:0]        rsp_id_r;
    logic [2*DATA_WIDTH-1:0]    rsp_data_r;
    logic                       busy_r;

    logic [ID_SPAN-1:0]         valid_ext_s;
    logic                       grant_found_s;
    logic [ID_WIDTH-1:0]        grant_idx_s;
    logic [ID_WIDTH-1:0]        cand_idx_s;
    logic [NUM_REQ-1:0]         grant_onehot_s;
    logic [DATA_WIDTH-1:0]      sel_a_s;
    logic [DATA_WIDTH-1:0]      sel_b_s;
    logic [2*DATA_WIDTH-1:0]    mult_out_s;

    // Round-robin search starting just after the last winner, wrapping at NUM_REQ.
    always_comb begin
        valid_ext_s                = {ID_SPAN{1'b0}};
        valid_ext_s[NUM_REQ-1:0]   = req_valid;
        grant_found_s              = 1'b0;
        grant_idx_s                = {ID_WIDTH{1'b0}};
        cand_idx_s                 = {ID_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx_s = ID_WIDTH'((int'(last_r) + 1 + k) % NUM_REQ);
            if (!grant_found_s && valid_ext_s[cand_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant vector and operand mux for the winning lane.
    always_comb begin
        grant_onehot_s = {NUM_REQ{1'b0}};
        sel_a_s        = {DATA_WIDTH{1'b0}};
        sel_b_s        = {DATA_WIDTH{1'b0}};
        if (grant_found_s) begin
            grant_onehot_s = NUM_REQ'(1) << grant_idx_s;
        end else begin
            grant_onehot_s = {NUM_REQ{1'b0}};
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = sel_a_s | ({DATA_WIDTH{grant_onehot_s[i]}} & req_a[i*DATA_WIDTH +: DATA_WIDTH]);
            sel_b_s = sel_b_s | ({DATA_WIDTH{grant_onehot_s[i]}} & req_b[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Ready only ever goes to a valid requester, and only while idle.
    assign req_ready = (state_r == ST_IDLE) ? grant_onehot_s : {NUM_REQ{1'b0}};

    mult_16 #(
        .MODE (0)
    ) u_mult_16 (
        .a   (op_a_r),
        .b   (op_b_r),
        .out (mult_out_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: grant -> multiply -> hold response until accepted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on grant, register product, hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r      <= ID_WIDTH'(NUM_REQ - 1);
            id_r        <= {ID_WIDTH{1'b0}};
            op_a_r      <= {DATA_WIDTH{1'b0}};
            op_b_r      <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_WIDTH{1'b0}};
            rsp_data_r  <= {(2*DATA_WIDTH){1'b0}};
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        op_a_r <= sel_a_s;
                        op_b_r <= sel_b_s;
                        id_r   <= grant_idx_s;
                        last_r <= grant_idx_s;
                    end else begin
                        last_r <= last_r;
                    end
                end
                ST_MUL: begin
                    rsp_data_r  <= mult_out_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;

endmodule
